// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the control FSM / multiply-divide unit and multdiv_sequencer.
// MULTDIV_SEQ_MTHILO_EN adds the mthi/mtlo/wdata direct-write path.
interface multdiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_ctrl;
  logic        md_reset;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_divzero;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULTDIV_SEQ_MTHILO_EN
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;

  modport master (
    output start, op, a_in, b_in, md_hi, md_lo, md_divzero, mthi, mtlo, wdata,
    input  md_a, md_b, md_ctrl, md_reset, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in, md_hi, md_lo, md_divzero, mthi, mtlo, wdata,
    output md_a, md_b, md_ctrl, md_reset, busy, done, div_zero, hi, lo
  );
`else
  modport master (
    output start, op, a_in, b_in, md_hi, md_lo, md_divzero,
    input  md_a, md_b, md_ctrl, md_reset, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a_in, b_in, md_hi, md_lo, md_divzero,
    output md_a, md_b, md_ctrl, md_reset, busy, done, div_zero, hi, lo
  );
`endif
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences the iterative mult/div unit: latches operands, runs it for exactly N clocks, captures HI/LO.
// Optional MULTDIV_SEQ_MTHILO_EN enables mthi/mtlo writes of HI/LO while idle.
module multdiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6
) (
  input  logic               clk,
  input  logic               reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [1:0]       CTRL_IDLE = 2'd0;
  localparam logic [1:0]       CTRL_MULT = 2'd1;
  localparam logic [1:0]       CTRL_DIV  = 2'd2;

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic             op_r;
  logic             zero_r;
  logic [31:0]      md_a_r;
  logic [31:0]      md_b_r;
  logic [1:0]       md_ctrl_r;
  logic             md_reset_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  logic             run_last_s;
  logic             hi_wr_s;
  logic             lo_wr_s;
  logic [31:0]      wdata_s;

  // Last iteration edge: the unit has then seen exactly N active edges.
  assign run_last_s = op_r ? (count_r == DIV_LAST) : (count_r == MULT_LAST);

`ifdef MULTDIV_SEQ_MTHILO_EN
  assign hi_wr_s = bus.mthi;
  assign lo_wr_s = bus.mtlo;
  assign wdata_s = bus.wdata;
`else
  assign hi_wr_s = 1'b0;
  assign lo_wr_s = 1'b0;
  assign wdata_s = 32'd0;
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      op_r       <= 1'b0;
      zero_r     <= 1'b0;
      md_a_r     <= 32'd0;
      md_b_r     <= 32'd0;
      md_ctrl_r  <= CTRL_IDLE;
      md_reset_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Direct writes are only honoured here; a simultaneous start still launches.
          if (hi_wr_s) hi_r <= wdata_s;
          if (lo_wr_s) lo_r <= wdata_s;
          if (bus.start) begin
            md_a_r     <= bus.a_in;
            md_b_r     <= bus.b_in;
            op_r       <= bus.op;
            zero_r     <= 1'b0;
            md_reset_r <= 1'b1;
            md_ctrl_r  <= CTRL_IDLE;
            busy_r     <= 1'b1;
            state_r    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          md_reset_r <= 1'b0;
          count_r    <= '0;
          if (op_r && (md_b_r == 32'd0)) begin
            zero_r     <= 1'b1;
            done_r     <= 1'b1;
            div_zero_r <= 1'b1;
            md_ctrl_r  <= CTRL_IDLE;
            state_r    <= ST_DONE;
          end else begin
            md_ctrl_r <= op_r ? CTRL_DIV : CTRL_MULT;
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.md_divzero) begin
            // Abort without touching HI/LO.
            zero_r     <= 1'b1;
            done_r     <= 1'b1;
            div_zero_r <= 1'b1;
            md_ctrl_r  <= CTRL_IDLE;
            state_r    <= ST_DONE;
          end else if (run_last_s) begin
            md_ctrl_r <= CTRL_IDLE;
            state_r   <= ST_CAPTURE;
          end else begin
            count_r <= count_r + 1'b1;
          end
        end
        ST_CAPTURE: begin
          hi_r       <= bus.md_hi;
          lo_r       <= bus.md_lo;
          done_r     <= 1'b1;
          div_zero_r <= zero_r;
          state_r    <= ST_DONE;
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          div_zero_r <= 1'b0;
          zero_r     <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          count_r    <= '0;
          zero_r     <= 1'b0;
          md_ctrl_r  <= CTRL_IDLE;
          md_reset_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          div_zero_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.md_a     = md_a_r;
  assign bus.md_b     = md_b_r;
  assign bus.md_ctrl  = md_ctrl_r;
  assign bus.md_reset = md_reset_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: behavioural mult/div unit, vector table, scoreboard, corner-case sequences.
// Exercises the MULTDIV_SEQ_MTHILO_EN path when that macro is defined.
module tb_multdiv_sequencer;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          elat;
    int          ectrl;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clk;
  logic reset;
  multdiv_sequencer_if bus();

  multdiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  int   ctrl_cnt = 0;
  int   rst_cnt  = 0;
  int   bad_cnt  = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   unit_cnt = 0;
  logic        cur_op = 1'b0;
  logic [31:0] cur_a  = 32'd0;
  logic [31:0] cur_b  = 32'd0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  int   ctrl_base, rst_base, bad_base;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference mult/div unit: result valid only after exactly 32 (mult) / 33 (div) active edges.
  function automatic logic [63:0] unit_calc(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    if (ctrl == 2'd1) begin
      pa = 64'($signed(a));
      pb = 64'($signed(b));
      return pa * pb;
    end
    if (b == 32'd0) return {32'hBAD0_0005, 32'hBAD0_0006};
    sa  = a;
    sbv = b;
    q = sa / sbv;
    r = sa % sbv;
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (bus.md_reset) begin
      unit_cnt  <= 0;
      bus.md_hi <= 32'hBAD0_0001;
      bus.md_lo <= 32'hBAD0_0002;
    end else if (bus.md_ctrl != 2'd0) begin
      unit_cnt <= unit_cnt + 1;
      if (unit_cnt + 1 == ((bus.md_ctrl == 2'd1) ? 32 : 33))
        {bus.md_hi, bus.md_lo} <= unit_calc(bus.md_ctrl, bus.md_a, bus.md_b);
      else
        {bus.md_hi, bus.md_lo} <= {32'hBAD0_0003, 32'hBAD0_0004};
    end
  end

  always @(negedge clk) begin
    if (bus.md_ctrl != 2'd0) ctrl_cnt <= ctrl_cnt + 1;
    if (bus.md_reset) rst_cnt <= rst_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if ((bus.md_ctrl != 2'd0) &&
        ((bus.md_ctrl != (cur_op ? 2'd2 : 2'd1)) || (bus.md_a != cur_a) || (bus.md_b != cur_b)))
      bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge right after E0.
  task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input logic push);
    exp_t e;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz;
      sb.push_back(e);
    end
    cur_op = op; cur_a = a; cur_b = b;
    ctrl_base = ctrl_cnt; rst_base = rst_cnt; bad_base = bad_cnt;
    bus.start = 1'b1; bus.op = op; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic complete(input int elat, input int ectrl);
    exp_t e;
    while (!bus.done && (cyc - t0) < 200) @(negedge clk);
    if (!bus.done) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within 200 cycles, expected latency %0d", elat);
      sb.delete();
    end else begin
      e = sb.pop_front();
      exp_done++;
      check("latency", 64'(cyc - t0), 64'(elat));
      check("hi", 64'(bus.hi), 64'(e.hi));
      check("lo", 64'(bus.lo), 64'(e.lo));
      check("div_zero", 64'(bus.div_zero), 64'(e.dz));
      check("busy_at_done", 64'(bus.busy), 64'd1);
      last_hi = e.hi; last_lo = e.lo;
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'd0);
      check("div_zero_one_cycle", 64'(bus.div_zero), 64'd0);
      check("busy_after_done", 64'(bus.busy), 64'd0);
      check("md_ctrl_cycles", 64'(ctrl_cnt - ctrl_base), 64'(ectrl));
      check("md_reset_cycles", 64'(rst_cnt - rst_base), 64'd1);
      check("md_ctrl_and_operand_stability", 64'(bad_cnt - bad_base), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 32};
    vecs[1] = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 35, 33};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 33};
    vecs[3] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'd1,         32'd0,         1'b0, 34, 32};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 34, 32};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF,  32'h0000_0010, 32'h0000_000F, 32'h07FF_FFFF, 1'b0, 35, 33};
    vecs[6] = '{1'b1, 32'd5,          32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFF, 1'b0, 35, 33};
    vecs[7] = '{1'b1, 32'h0000_0451,  32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 35, 33};
    vecs[8] = '{1'b1, 32'h0000_1234,  32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1, 1,  0};

    clk = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a_in = 32'd0; bus.b_in = 32'd0; bus.md_divzero = 1'b0;
`ifdef MULTDIV_SEQ_MTHILO_EN
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
    check("reset_md_ctrl", 64'(bus.md_ctrl), 64'd0);
    check("reset_md_reset", 64'(bus.md_reset), 64'd0);
    check("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("reset_md_a_b", {bus.md_a, bus.md_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edz, 1'b1);
      complete(vecs[i].elat, vecs[i].ectrl);
    end

    // Unit-reported divide-by-zero during RUN aborts without writing HI/LO.
    launch(1'b1, 32'd50, 32'd5, last_hi, last_lo, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    bus.md_divzero = 1'b1;
    @(negedge clk);
    bus.md_divzero = 1'b0;
    complete(11, 10);

`ifdef MULTDIV_SEQ_MTHILO_EN
    bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_idle_hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
    check("mthi_idle_lo_kept", 64'(bus.lo), 64'(last_lo));
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});
    bus.mtlo = 1'b1; bus.wdata = 32'h1357_9BDF;
    launch(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
    bus.mtlo = 1'b0;
    check("mtlo_with_start", 64'(bus.lo), 64'h0000_0000_1357_9BDF);
    check("start_with_mtlo_busy", 64'(bus.busy), 64'd1);
    repeat (3) @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi_busy_ignored", 64'(bus.hi), 64'h0000_0000_0BAD_F00D);
    complete(34, 32);
`endif

    // Second start mid-run is ignored; reset mid-run aborts with no done.
    launch(1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a_in = 32'h55; bus.b_in = 32'h66;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_ignored_md_a", 64'(bus.md_a), 64'd3);
    check("restart_ignored_md_b", 64'(bus.md_b), 64'd4);
    check("restart_ignored_ctrl", 64'(bus.md_ctrl), 64'd1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("midreset_md_ctrl", 64'(bus.md_ctrl), 64'd0);
    check("midreset_md_a", 64'(bus.md_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt), 64'(exp_done));
    check("midreset_still_idle", 64'(bus.busy), 64'd0);

    launch(vecs[3].op, vecs[3].a, vecs[3].b, vecs[3].ehi, vecs[3].elo, vecs[3].edz, 1'b1);
    complete(vecs[3].elat, vecs[3].ectrl);
    check("total_done_pulses", 64'(done_cnt), 64'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
